// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// Op codes match the decoder's 3-bit access-type field.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_READ,
    S_RMW_WRITE
  } lsu_state_e;

  function automatic logic lsu_is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane select/extend for loads and lane merge for sub-word stores.
// Purely combinational; shared by the LOAD and RMW_READ states.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word_in,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_ext,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word_in[7:0];
      2'd1:    w_byte = i_word_in[15:8];
      2'd2:    w_byte = i_word_in[23:16];
      default: w_byte = i_word_in[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word_in[31:16] : i_word_in[15:0];
  end

  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    o_load_ext = i_word_in;
    o_merged   = i_word_in;
    case (i_op)
      OP_LH:  o_load_ext = {{16{w_half[15]}}, w_half};
      OP_LHU: o_load_ext = {16'h0000, w_half};
      OP_LB:  o_load_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_load_ext = {24'h000000, w_byte};
      OP_SH: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_store_data[15:0];
        else              o_merged[15:0]  = i_store_data[15:0];
      end
      OP_SB: begin
        case (i_addr_lo)
          2'd0:    o_merged[7:0]   = i_store_data[7:0];
          2'd1:    o_merged[15:8]  = i_store_data[7:0];
          2'd2:    o_merged[23:16] = i_store_data[7:0];
          default: o_merged[31:24] = i_store_data[7:0];
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: word-only memory initiator with read-modify-write
// for sub-word stores, load extension, address-error detection and stall.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_exc_adel,
  output logic        o_exc_ades,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic [31:0] o_mem_pc,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  lsu_state_e  r_state, w_next_state;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_pc, r_merged, r_rdata;
  logic        r_done, r_adel, r_ades;
  logic        w_is_load, w_err, w_we;
  logic [31:0] w_load_ext, w_merged;

  assign w_is_load = lsu_is_load(i_op);
  assign w_err     = lsu_misaligned(i_op, i_addr[1:0]) ||
                     ({2'b00, i_addr[31:2]} >= MEM_WORDS_U);

  lsu_lane u_lane (
    .i_op         (r_op),
    .i_addr_lo    (r_addr[1:0]),
    .i_word_in    (i_mem_rdata),
    .i_store_data (r_wdata),
    .o_load_ext   (w_load_ext),
    .o_merged     (w_merged)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    o_mem_addr   = 32'h0;
    o_mem_wdata  = 32'h0;
    o_mem_pc     = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (i_req && !w_err) begin
          if (w_is_load)          w_next_state = S_LOAD;
          else if (i_op == OP_SW) w_next_state = S_STORE;
          else                    w_next_state = S_RMW_READ;
        end
      end
      S_LOAD: begin
        o_mem_addr   = {r_addr[31:2], 2'b00};
        o_mem_pc     = r_pc;
        w_next_state = S_IDLE;
      end
      S_STORE: begin
        o_mem_addr   = {r_addr[31:2], 2'b00};
        o_mem_pc     = r_pc;
        o_mem_wdata  = r_wdata;
        w_we         = 1'b1;
        w_next_state = S_IDLE;
      end
      S_RMW_READ: begin
        o_mem_addr   = {r_addr[31:2], 2'b00};
        o_mem_pc     = r_pc;
        w_next_state = S_RMW_WRITE;
      end
      S_RMW_WRITE: begin
        o_mem_addr   = {r_addr[31:2], 2'b00};
        o_mem_pc     = r_pc;
        o_mem_wdata  = r_merged;
        w_we         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_LW;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_pc     <= 32'h0;
      r_merged <= 32'h0;
      r_rdata  <= 32'h0;
      r_done   <= 1'b0;
      r_adel   <= 1'b0;
      r_ades   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_adel <= 1'b0;
      r_ades <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req && w_err) begin
            r_adel <= w_is_load;
            r_ades <= !w_is_load;
          end else if (i_req) begin
            r_op    <= i_op;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_pc    <= i_pc;
          end
        end
        S_LOAD: begin
          r_rdata <= w_load_ext;
          r_done  <= 1'b1;
        end
        S_RMW_READ:  r_merged <= w_merged;
        S_STORE,
        S_RMW_WRITE: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // The write strobe is killed by reset in the same cycle, so a reset landing in RMW_WRITE drops the write.
  assign o_mem_we   = w_we && !reset;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_rdata    = r_rdata;
  assign o_exc_adel = r_adel;
  assign o_exc_ades = r_ades;

endmodule
